fade_pwm_multi: RTL and testbench

FADE_PWM_MULTI -- requirements
Module: fade_pwm_multi

---
 rtl/fade_pkg.sv | 22 ++
 rtl/fade_channel.sv | 137 +++++++++++++
 rtl/fade_pwm_multi.sv | 98 +++++++++
 tb/tb_fade_pwm_multi.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fade_pkg.sv
// rtl/fade_pkg.sv - shared types and helpers for the multi-channel fade PWM
//
// Purpose: channel FSM state encoding and the per-channel phase-offset rule.
// Ports:   none (package).
// Config:  FADE_DWELL_EN selects whether HOLD_HI/HOLD_LO are ever entered;
//          the enum always carries all four states.
package fade_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    FALL    = 2'd1,
    HOLD_HI = 2'd2,
    HOLD_LO = 2'd3
  } fade_state_t;

  // Position of channel ch within a 2*steps-long triangle, spreading the
  // channels evenly around one full up/down cycle.
  function automatic int phase_offset(input int ch, input int steps, input int num_ch);
    return (ch * 2 * steps) / num_ch;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// rtl/fade_channel.sv - one fade channel: ramp FSM, level, dwell, shadow duty, compare
//
// Purpose: ramps a brightness level up and down one step per step_tick and
//          turns it into a PWM waveform against the shared period counter.
// Ports:   clk, rst (sync, active high)
//          step_tick  - advance the ramp by one step this cycle
//          period_end - shared PWM counter is at its last count
//          pwm_cnt    - shared PWM counter value
//          pwm_value  - registered duty (level * STEP_VAL)
//          pwm_out    - registered PWM waveform
// Config:  FADE_DWELL_EN adds HOLD_HI/HOLD_LO and the dwell counter.
module fade_channel
  import fade_pkg::*;
#(
  parameter int CH_IDX       = 0,
  parameter int NUM_CH       = 3,
  parameter int STEPS        = 200,
  parameter int DWELL_STEPS  = 50,
  parameter int STEP_VAL     = 6,
  parameter int VW           = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_tick,
  input  logic          period_end,
  input  logic [VW-1:0] pwm_cnt,
  output logic [VW-1:0] pwm_value,
  output logic          pwm_out
);

  localparam int LW       = $clog2(STEPS + 1);
  localparam int PH       = phase_offset(CH_IDX, STEPS, NUM_CH);
  localparam int INIT_LVL = (PH < STEPS) ? PH : (2 * STEPS - PH);
  localparam fade_state_t INIT_STATE = (PH < STEPS) ? RISE : FALL;
  localparam logic [LW-1:0] INIT_LEVEL = LW'(INIT_LVL);
  localparam logic [LW-1:0] TOP_M1     = LW'(STEPS - 1);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);

  fade_state_t   state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [VW-1:0] pwm_value_q, pwm_value_d;
  logic [VW-1:0] shadow_q, shadow_d;
  logic          pwm_out_q, pwm_out_d;

`ifdef FADE_DWELL_EN
  localparam int DWW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_STEPS - 1);
  logic [DWW-1:0] dwell_q, dwell_d;
`endif

  always_comb begin
    state_d = state_q;
    level_d = level_q;
`ifdef FADE_DWELL_EN
    dwell_d = dwell_q;
`endif
    if (rst) begin
      state_d = INIT_STATE;
      level_d = INIT_LEVEL;
`ifdef FADE_DWELL_EN
      dwell_d = '0;
`endif
    end else if (step_tick) begin
      case (state_q)
        RISE: begin
          level_d = level_q + LEVEL_ONE;
          // Transition decided on the step that lands on the peak.
          if (level_q == TOP_M1) begin
`ifdef FADE_DWELL_EN
            state_d = HOLD_HI;
`else
            state_d = FALL;
`endif
          end
        end
        FALL: begin
          level_d = level_q - LEVEL_ONE;
          if (level_q == LEVEL_ONE) begin
`ifdef FADE_DWELL_EN
            state_d = HOLD_LO;
`else
            state_d = RISE;
`endif
          end
        end
`ifdef FADE_DWELL_EN
        HOLD_HI: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            state_d = FALL;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        HOLD_LO: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            state_d = RISE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
`endif
        default: state_d = RISE;
      endcase
    end
  end

  // Duty follows the level one cycle later; the shadow copy only moves at
  // the period boundary so a period never sees a mid-period duty change.
  always_comb begin
    pwm_value_d = VW'(int'(level_q) * STEP_VAL);
    shadow_d    = shadow_q;
    pwm_out_d   = 1'b0;
    if (rst) begin
      shadow_d = '0;
    end else begin
      if (period_end) shadow_d = pwm_value_q;
      pwm_out_d = (pwm_cnt < shadow_q);
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    level_q     <= level_d;
    pwm_value_q <= pwm_value_d;
    shadow_q    <= shadow_d;
    pwm_out_q   <= pwm_out_d;
`ifdef FADE_DWELL_EN
    dwell_q     <= dwell_d;
`endif
  end

  assign pwm_value = pwm_value_q;
  assign pwm_out   = pwm_out_q;

endmodule

// File: rtl/fade_pwm_multi.sv
// rtl/fade_pwm_multi.sv - multi-channel triangle fade driving PWM outputs
//
// Purpose: owns the shared step and PWM counters and instantiates one
//          fade_channel per output.
// Ports:   clk, rst (sync, active high), en (step advance enable)
//          pwm_value    - NUM_CH packed duties, channel i at [i*VW +: VW]
//          pwm_out      - NUM_CH PWM waveforms
//          step_tick    - one-cycle pulse per brightness step
//          period_start - one-cycle pulse when the PWM counter is 0
// Config:  define FADE_DWELL_EN to hold DWELL_STEPS steps at peak and trough.
module fade_pwm_multi
  import fade_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int PWM_INTERVAL  = 1200,
  parameter int STEP_INTERVAL = 12000,
  parameter int STEPS         = 200,
  parameter int DWELL_STEPS   = 50,
  localparam int STEP_VAL     = PWM_INTERVAL / STEPS,
  localparam int VW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [NUM_CH*VW-1:0] pwm_value,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 step_tick,
  output logic                 period_start
);

  localparam int SW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_INTERVAL - 1);
  localparam logic [VW-1:0] PWM_LAST  = VW'(PWM_INTERVAL - 1);

  if (STEPS < 2 || STEPS > PWM_INTERVAL) begin : g_bad_steps
    $error("fade_pwm_multi: STEPS out of range");
  end
  if (DWELL_STEPS < 1 || NUM_CH < 1) begin : g_bad_cfg
    $error("fade_pwm_multi: DWELL_STEPS and NUM_CH must be >= 1");
  end

  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [VW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          step_tick_q, step_tick_d;
  logic          period_start_q, period_start_d;
  logic          period_end;

  assign period_end = (pwm_cnt_q == PWM_LAST);

  always_comb begin
    step_cnt_d     = step_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    step_tick_d    = 1'b0;
    period_start_d = 1'b0;
    if (rst) begin
      step_cnt_d = '0;
      pwm_cnt_d  = '0;
    end else begin
      if (en) begin
        step_cnt_d  = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + 1'b1;
        step_tick_d = (step_cnt_q == STEP_LAST);
      end
      pwm_cnt_d      = period_end ? '0 : pwm_cnt_q + 1'b1;
      // Registered so the pulse lines up with the cycle the counter reads 0.
      period_start_d = period_end;
    end
  end

  always_ff @(posedge clk) begin
    step_cnt_q     <= step_cnt_d;
    pwm_cnt_q      <= pwm_cnt_d;
    step_tick_q    <= step_tick_d;
    period_start_q <= period_start_d;
  end

  assign step_tick    = step_tick_q;
  assign period_start = period_start_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fade_channel #(
      .CH_IDX      (g),
      .NUM_CH      (NUM_CH),
      .STEPS       (STEPS),
      .DWELL_STEPS (DWELL_STEPS),
      .STEP_VAL    (STEP_VAL),
      .VW          (VW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .step_tick  (step_tick_q),
      .period_end (period_end),
      .pwm_cnt    (pwm_cnt_q),
      .pwm_value  (pwm_value[g*VW +: VW]),
      .pwm_out    (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_fade_pwm_multi.sv
// tb/tb_fade_pwm_multi.sv - scoreboard bench for fade_pwm_multi
//
// Purpose: drives random en/rst and compares every output cycle against a
//          triangle-position reference model. Honours FADE_DWELL_EN.
// Ports:   none (top-level bench).
module tb_fade_pwm_multi;

  localparam int NCH = 3;
  localparam int PI  = 12;
  localparam int SI  = 4;
  localparam int S   = 6;
  localparam int DW  = 2;
  localparam int SV  = PI / S;
  localparam int VW  = $clog2(PI + 1);
  localparam int W   = NCH * VW;
`ifdef FADE_DWELL_EN
  localparam int D = DW;
`else
  localparam int D = 0;
`endif
  localparam int P = 2 * S + 2 * D;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic [W-1:0]   pwm_value;
  logic [NCH-1:0] pwm_out;
  logic           step_tick;
  logic           period_start;

  fade_pwm_multi #(
    .NUM_CH        (NCH),
    .PWM_INTERVAL  (PI),
    .STEP_INTERVAL (SI),
    .STEPS         (S),
    .DWELL_STEPS   (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pwm_value    (pwm_value),
    .pwm_out      (pwm_out),
    .step_tick    (step_tick),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic           ps;
    logic           st;
    logic [NCH-1:0] po;
    logic [W-1:0]   v;
    logic           vok;
  } item_t;

  item_t        pwm_q[$];
  logic [W-1:0] step_q[$];
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Level at a position on the triangle: rise 0..S, hold at S for D steps,
  // fall to 0, hold at 0 for D steps, repeat every P steps.
  function automatic int lvl(input int p_in);
    int p;
    p = p_in % P;
    if (p <= S)         return p;
    if (p <= S + D)     return S;
    if (p <= 2 * S + D) return 2 * S + D - p;
    return 0;
  endfunction

  function automatic int pos0(input int ch);
    int k;
    k = (ch * 2 * S) / NCH;
    return (k < S) ? k : k + D;
  endfunction

  // Reference model state
  int             cyc = 0;
  bit             started = 0;
  int             cnt = 0;
  int             en_cnt = 0;
  int             pos[NCH];
  int             duty[NCH];
  logic [W-1:0]   vals = '0;
  logic           vals_ok = 1'b0;
  logic [W-1:0]   pend_v = '0;
  int             pend_due = -1;

  task automatic do_cycle(input logic r, input logic e);
    item_t          it;
    logic           ps, st;
    logic [NCH-1:0] po;
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
    cyc++;
    ps = 1'b0;
    st = 1'b0;
    po = '0;
    if (r) begin
      started = 1;
      cnt = 0;
      en_cnt = 0;
      vals_ok = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        duty[ch] = 0;
        pos[ch]  = pos0(ch);
        pend_v[ch*VW +: VW] = VW'(lvl(pos[ch]) * SV);
      end
      pend_due = cyc + 1;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        po[ch] = (cnt < duty[ch]);
        if (cnt == PI - 1) duty[ch] = int'(vals[ch*VW +: VW]);
      end
      cnt = (cnt + 1) % PI;
      ps  = (cnt == 0);
      if (e) begin
        en_cnt++;
        if (en_cnt % SI == 0) begin
          st = 1'b1;
          for (int ch = 0; ch < NCH; ch++) begin
            pos[ch]++;
            pend_v[ch*VW +: VW] = VW'(lvl(pos[ch]) * SV);
          end
          pend_due = cyc + 2;
          step_q.push_back(pend_v);
        end
      end
    end
    if (pend_due == cyc) begin
      vals    = pend_v;
      vals_ok = 1'b1;
    end
    if (started) begin
      it.cyc = cyc; it.ps = ps; it.st = st; it.po = po; it.v = vals; it.vok = vals_ok;
      pwm_q.push_back(it);
    end
  endtask

  // Monitor: one expectation per cycle, plus the per-step value scoreboard.
  logic [W-1:0] step_exp;
  int           step_due = -1;
  always @(negedge clk) begin
    item_t it;
    if (pwm_q.size() > 0) begin
      it = pwm_q.pop_front();
      check("period_start", 32'(period_start), 32'(it.ps));
      check("step_tick", 32'(step_tick), 32'(it.st));
      check("pwm_out", 32'(pwm_out), 32'(it.po));
      if (it.vok) check("pwm_value", 32'(pwm_value), 32'(it.v));
      if (step_tick === 1'b1) begin
        if (step_q.size() == 0) begin
          check("step_unexpected", 32'(1), 32'(0));
        end else begin
          step_exp = step_q.pop_front();
          step_due = it.cyc + 2;
        end
      end
      if (step_due == it.cyc) begin
        check("step_value", 32'(pwm_value), 32'(step_exp));
        step_due = -1;
      end
    end
  end

  task automatic reset_and_check(input string nm);
    logic [W-1:0] exp_init;
    exp_init = '0;
    for (int ch = 0; ch < NCH; ch++) exp_init[ch*VW +: VW] = VW'(lvl(pos0(ch)) * SV);
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b0, 1'b0);
    check({nm, "_value"}, 32'(pwm_value), {20'd0, 4'd8, 4'd8, 4'd0});
    check({nm, "_model"}, 32'(exp_init), {20'd0, 4'd8, 4'd8, 4'd0});
    check({nm, "_pwm_out"}, 32'(pwm_out), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0);
  endtask

  initial begin
    bit found;
    int p;
    reset_and_check("reset");

    for (int i = 0; i < 300; i++) do_cycle(1'b0, $urandom_range(0, 9) < 8);
    idle(100);
    for (int i = 0; i < 400; i++) do_cycle(1'b0, 1'b1);

    // Land channel 0 in its peak dwell, then reset.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      do_cycle(1'b0, 1'b1);
      p = pos[0] % P;
      found = (D > 0) ? (p > S && p <= S + D) : (p == S);
    end
    check("hold_hi_reached", 32'(found), 32'd1);
    idle(4);
    reset_and_check("reset_hold");

    for (int i = 0; i < 300; i++) do_cycle(1'b0, $urandom_range(0, 9) < 6);
    idle(4);
    reset_and_check("reset_mid");
    for (int i = 0; i < 200; i++) do_cycle(1'b0, $urandom_range(0, 9) < 9);
    idle(4);

    @(negedge clk);
    #1;
    check("step_queue_drained", 32'(step_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
